// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: run-control stage for the core.
// Turns the divided slow clock, a bouncing step push-button and the mode switches into a
// registered single-cycle-qualified clock enable (cpu_en) in the clk domain. Supports halt,
// full-speed, slow-tick and single-step modes, plus a sticky break entered on halt_req.
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   slow_clk      divided clock, treated as an asynchronous level
//   step_btn      raw push-button, active high, bouncing
//   mode          raw switches: 00 halt, 01 run, 10 slow, 11 step
//   halt_req      core break request (clk domain level)
//   count_clr     synchronous clear of step_count (wins over increment)
//   cpu_en        core clock enable (registered)
//   halted        1 while in halt or break (registered)
//   state         current FSM state encoding for the LED display
//   step_count    number of cycles with cpu_en=1, wraps
module cpu_step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned COUNT_W         = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               slow_clk,
    input  logic               step_btn,
    input  logic [1:0]         mode,
    input  logic               halt_req,
    input  logic               count_clr,
    output logic               cpu_en,
    output logic               halted,
    output logic [2:0]         state,
    output logic [COUNT_W-1:0] step_count
);

    localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        StHalt  = 3'd0,
        StRun   = 3'd1,
        StSlow  = 3'd2,
        StStep  = 3'd3,
        StBreak = 3'd4
    } state_e;

    // Synchronisers; slow_s3 is the edge-detect history stage.
    logic       slow_s1, slow_s2, slow_s3;
    logic       btn_s1, btn_s2;
    logic [1:0] mode_s1, mode_s2;

    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           db_lvl_q, db_lvl_d;

    state_e               state_q, state_d, mode_state;
    logic                 cpu_en_q, cpu_en_d;
    logic                 halted_q, halted_d;
    logic [COUNT_W-1:0]   count_q;

    logic tick, press, btn_diff, db_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slow_s1  <= 1'b0;
            slow_s2  <= 1'b0;
            slow_s3  <= 1'b0;
            btn_s1   <= 1'b0;
            btn_s2   <= 1'b0;
            mode_s1  <= 2'b00;
            mode_s2  <= 2'b00;
            db_cnt_q <= '0;
            db_lvl_q <= 1'b0;
            state_q  <= StHalt;
            cpu_en_q <= 1'b0;
            halted_q <= 1'b1;
            count_q  <= '0;
        end else begin
            slow_s1  <= slow_clk;
            slow_s2  <= slow_s1;
            slow_s3  <= slow_s2;
            btn_s1   <= step_btn;
            btn_s2   <= btn_s1;
            mode_s1  <= mode;
            mode_s2  <= mode_s1;
            db_cnt_q <= db_cnt_d;
            db_lvl_q <= db_lvl_d;
            state_q  <= state_d;
            cpu_en_q <= cpu_en_d;
            halted_q <= halted_d;
            if (count_clr) begin
                count_q <= '0;
            end else if (cpu_en_q) begin
                count_q <= count_q + COUNT_W'(1);
            end
        end
    end

    assign tick = slow_s2 & ~slow_s3;

    // Debounce: count consecutive cycles in which the synced button disagrees with the
    // accepted level; a press is the cycle the accepted level flips to 1.
    always_comb begin
        btn_diff = (btn_s2 != db_lvl_q);
        db_done  = btn_diff && (db_cnt_q == DbMax);
        press    = db_done & btn_s2;
        db_lvl_d = db_done ? btn_s2 : db_lvl_q;
        if (!btn_diff || db_done) begin
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DbW'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        cpu_en_d   = 1'b0;
        mode_state = state_e'({1'b0, mode_s2});
        if (state_q == StBreak) begin
            // The exit press only releases the break; it never produces an enable.
            if (press) begin
                state_d = mode_state;
            end
        end else if (halt_req) begin
            state_d = StBreak;
        end else begin
            state_d = mode_state;
            // A tick or press landing in a mode-switch cycle is dropped.
            if (mode_state == state_q) begin
                case (state_q)
                    StRun:   cpu_en_d = 1'b1;
                    StSlow:  cpu_en_d = tick;
                    StStep:  cpu_en_d = press;
                    default: cpu_en_d = 1'b0;
                endcase
            end
        end
        halted_d = (state_d == StHalt) || (state_d == StBreak);
    end

    assign cpu_en     = cpu_en_q;
    assign halted     = halted_q;
    assign state      = state_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Testbench for cpu_step_ctrl: directed phases plus a randomized phase, checked by a
// scoreboard fed from a behavioural model built on input history queues.
module tb_cpu_step_ctrl;

    localparam int unsigned DEB = 4;
    localparam int unsigned CW  = 6;

    logic          clk;
    logic          rst_n;
    logic          slow_clk;
    logic          step_btn;
    logic [1:0]    mode;
    logic          halt_req;
    logic          count_clr;
    logic          cpu_en;
    logic          halted;
    logic [2:0]    state;
    logic [CW-1:0] step_count;

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .COUNT_W         (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .slow_clk   (slow_clk),
        .step_btn   (step_btn),
        .mode       (mode),
        .halt_req   (halt_req),
        .count_clr  (count_clr),
        .cpu_en     (cpu_en),
        .halted     (halted),
        .state      (state),
        .step_count (step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          en;
        logic          hlt;
        logic [2:0]    st;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   en_seen = 0;

    // Model state. Histories hold raw input samples, newest first: index k = k+1 edges ago.
    logic [2:0]    m_state;
    logic          m_en;
    logic          m_hlt;
    logic [CW-1:0] m_cnt;
    logic          m_db;
    int            m_run;
    logic          sl_h[$];
    logic          bt_h[$];
    logic [1:0]    md_h[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string name);
        check(name, 16'({cpu_en, halted, state, step_count}),
              16'({1'b0, 1'b1, 3'd0, {CW{1'b0}}}));
    endtask

    task automatic model_reset();
        m_state = 3'd0;
        m_en    = 1'b0;
        m_hlt   = 1'b1;
        m_cnt   = '0;
        m_db    = 1'b0;
        m_run   = 0;
        sl_h    = '{1'b0, 1'b0, 1'b0};
        bt_h    = '{1'b0, 1'b0};
        md_h    = '{2'b00, 2'b00};
        sb.delete();
    endtask

    task automatic model_step();
        logic       tick;
        logic       press;
        logic [1:0] md;
        logic [2:0] nxt;
        logic       en_n;
        // Control logic sees each input two edges late; the slow edge compares 2 vs 3 ago.
        tick  = sl_h[1] & ~sl_h[2];
        md    = md_h[1];
        press = 1'b0;
        if (bt_h[1] != m_db) begin
            m_run++;
            if (m_run == int'(DEB)) begin
                m_db  = bt_h[1];
                press = m_db;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        if (count_clr)  m_cnt = '0;
        else if (m_en)  m_cnt = m_cnt + 1'b1;
        if (m_state == 3'd4) begin
            nxt  = press ? {1'b0, md} : 3'd4;
            en_n = 1'b0;
        end else if (halt_req) begin
            nxt  = 3'd4;
            en_n = 1'b0;
        end else begin
            nxt  = {1'b0, md};
            en_n = (nxt == m_state) &&
                   ((md == 2'b01) || (md == 2'b10 && tick) || (md == 2'b11 && press));
        end
        m_state = nxt;
        m_en    = en_n;
        m_hlt   = (nxt == 3'd0) || (nxt == 3'd4);
        sl_h.push_front(slow_clk);
        void'(sl_h.pop_back());
        bt_h.push_front(step_btn);
        void'(bt_h.pop_back());
        md_h.push_front(mode);
        void'(md_h.pop_back());
        sb.push_back('{en: m_en, hlt: m_hlt, st: m_state, cnt: m_cnt});
    endtask

    // Model process: one expected response per active edge out of reset.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Monitor: pops and compares one expected response per clock, 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb.size() > 0) begin
                e = sb.pop_front();
                check("cycle", 16'({cpu_en, halted, state, step_count}), 16'(e));
                if (cpu_en) en_seen++;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int start;
        int btn_left;
        int sl_left;
        rst_n     = 1'b0;
        slow_clk  = 1'b0;
        step_btn  = 1'b0;
        mode      = 2'b00;
        halt_req  = 1'b0;
        count_clr = 1'b0;
        cycles(3);
        check_reset("reset_init");
        rst_n = 1'b1;
        cycles(5);

        // Full speed.
        mode = 2'b01;
        cycles(30);

        // Break on a one-cycle halt request, released by a press.
        halt_req = 1'b1;
        cycles(1);
        halt_req = 1'b0;
        cycles(4);
        check("break_state", 16'({halted, state}), 16'({1'b1, 3'd4}));
        step_btn = 1'b1;
        cycles(10);
        step_btn = 1'b0;
        cycles(10);
        check("break_exit", 16'(state), 16'(3'd1));

        // Slow mode, slow_clk period 20.
        mode = 2'b10;
        for (int p = 0; p < 5; p++) begin
            slow_clk = 1'b1;
            cycles(10);
            slow_clk = 1'b0;
            cycles(10);
        end

        // Step mode: bouncing button then a clean hold gives exactly one enable.
        mode = 2'b11;
        cycles(6);
        start = en_seen;
        for (int i = 0; i < 10; i++) begin
            step_btn = ~i[0];
            cycles(1);
        end
        step_btn = 1'b1;
        cycles(8);
        step_btn = 1'b0;
        cycles(10);
        check("step_one_pulse", 16'(en_seen - start), 16'd1);

        // Clear wins over increment at all-ones, then run through a wrap.
        mode = 2'b01;
        for (int i = 0; i < 200 && m_cnt != '1; i++) cycles(1);
        check("count_all_ones", 16'(step_count), 16'({CW{1'b1}}));
        count_clr = 1'b1;
        cycles(1);
        count_clr = 1'b0;
        check("clr_priority", 16'(step_count), 16'd0);
        cycles(70);

        // Randomized phase.
        btn_left = 0;
        sl_left  = 0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
            halt_req  = ($urandom_range(31) == 0);
            count_clr = ($urandom_range(31) == 0);
            if (btn_left == 0) begin
                step_btn = 1'($urandom_range(1));
                btn_left = int'($urandom_range(12, 1));
            end else begin
                btn_left--;
            end
            if (sl_left == 0) begin
                slow_clk = ~slow_clk;
                sl_left  = int'($urandom_range(12, 3));
            end else begin
                sl_left--;
            end
            cycles(1);
        end

        // Reset while a slow tick is in flight.
        halt_req  = 1'b0;
        count_clr = 1'b0;
        slow_clk  = 1'b0;
        step_btn  = 1'b1;
        cycles(8);
        step_btn = 1'b0;
        mode     = 2'b10;
        cycles(12);
        slow_clk = 1'b1;
        cycles(2);
        rst_n = 1'b0;
        #1;
        check_reset("reset_mid_slow");
        cycles(2);
        check_reset("reset_hold");
        slow_clk = 1'b0;
        mode     = 2'b01;
        rst_n    = 1'b1;
        cycles(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
